// File: rtl/sum_level_pkg.sv
// sum_level_pkg: level encoding, default thresholds and the hysteretic band classifier
//   level_t  : LVL_LOW/LVL_MID/LVL_HIGH/LVL_OVER committed-level encoding
//   band_of  : candidate level for a sum given the current level; upward moves use
//              exact thresholds, downward moves require sum < T-hyst
package sum_level_pkg;
  typedef enum logic [1:0] {LVL_LOW, LVL_MID, LVL_HIGH, LVL_OVER} level_t;
  localparam int unsigned DEF_SUM_W = 4;
  localparam int unsigned DEF_T_MID = 4;
  localparam int unsigned DEF_T_HIGH = 8;
  localparam int unsigned DEF_T_OVER = 12;
  localparam int unsigned DEF_HYST = 1;
  localparam int unsigned DEF_DEB_CYC = 2;
  function automatic level_t band_of(input int unsigned s, input level_t cur,
                                     input int unsigned t_mid, input int unsigned t_high,
                                     input int unsigned t_over, input int unsigned hyst);
    logic [1:0] up, dn;
    up = 2'(s >= t_mid) + 2'(s >= t_high) + 2'(s >= t_over);
    // s + hyst >= t is s >= t - hyst without unsigned underflow
    dn = 2'(s + hyst >= t_mid) + 2'(s + hyst >= t_high) + 2'(s + hyst >= t_over);
    return up > cur ? level_t'(up) : dn < cur ? level_t'(dn) : cur;
  endfunction
endpackage

// File: rtl/sum_level_debounce.sv
// sum_level_debounce: candidate/count engine committing a new value after DEB_CYC valid samples
//   clk, rst_n : clock, async active-low reset
//   valid_i    : sample qualifier; cand/cnt hold while low
//   clr_i      : discard candidate and count (cand returns to 0)
//   raw_i      : candidate value for this sample
//   state_i    : currently committed value (held by the parent)
//   commit_o   : combinational, parent loads raw_i into its state on this edge
//   pending_o  : registered, candidate differs from state with debounce in progress
module sum_level_debounce #(
  parameter int unsigned DEB_CYC = 2,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  logic         clr_i,
  input  logic [W-1:0] raw_i,
  input  logic [W-1:0] state_i,
  output logic         commit_o,
  output logic         pending_o
);
  localparam int unsigned CW = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] DEB = CW'(DEB_CYC);
  logic [W-1:0] cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_n;
  logic pend_q, pend_d, moved;
  always_comb begin
    moved = raw_i != state_i;
    // a new candidate restarts at 1; a repeated one gains a count
    cnt_n = raw_i == cand_q ? cnt_q + CW'(1) : CW'(1);
    commit_o = valid_i & ~clr_i & moved & (cnt_n == DEB);
    cand_d = clr_i ? '0 : valid_i ? raw_i : cand_q;
    cnt_d = clr_i ? '0 : ~valid_i ? cnt_q : (~moved | commit_o) ? '0 : cnt_n;
    pend_d = (cand_d != state_i) & (cnt_d != '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cand_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
    end else begin
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
    end
  assign pending_o = pend_q;
endmodule

// File: rtl/sum_level_tracker.sv
// sum_level_tracker: hysteretic, debounced LOW/MID/HIGH/OVER classification of an unsigned sum
//   clk, rst_n  : clock, async active-low reset
//   sum_i       : SUM_W-bit unsigned sample, used only when sum_valid_i is high
//   clr_over_i  : sticky-OVER clear, effective only with SUM_LVL_STICKY_OVER_EN defined
//   state_o     : committed level 0=LOW 1=MID 2=HIGH 3=OVER, registered
//   state_chg_o : one-cycle pulse when state_o takes a new value
//   pending_o   : candidate differs from state, debounce in progress
// Build option SUM_LVL_STICKY_OVER_EN: OVER latches until clr_over_i.
module sum_level_tracker
  import sum_level_pkg::*;
#(
  parameter int unsigned SUM_W = DEF_SUM_W,
  parameter int unsigned T_MID = DEF_T_MID,
  parameter int unsigned T_HIGH = DEF_T_HIGH,
  parameter int unsigned T_OVER = DEF_T_OVER,
  parameter int unsigned HYST = DEF_HYST,
  parameter int unsigned DEB_CYC = DEF_DEB_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SUM_W-1:0] sum_i,
  input  logic             sum_valid_i,
  input  logic             clr_over_i,
  output logic [1:0]       state_o,
  output logic             state_chg_o,
  output logic             pending_o
);
  level_t state_q, state_d, raw, band;
  logic chg_q, chg_d, clr, commit;
  assign band = band_of(32'(sum_i), state_q, T_MID, T_HIGH, T_OVER, HYST);
`ifdef SUM_LVL_STICKY_OVER_EN
  // a committed OVER pins the candidate to OVER so no exit can debounce
  assign raw = state_q == LVL_OVER ? LVL_OVER : band;
  assign clr = clr_over_i;
`else
  logic unused_clr_over;
  assign unused_clr_over = clr_over_i;
  assign raw = band;
  assign clr = 1'b0;
`endif
  sum_level_debounce #(.DEB_CYC(DEB_CYC), .W(2)) u_deb (
    .clk(clk),
    .rst_n(rst_n),
    .valid_i(sum_valid_i),
    .clr_i(clr),
    .raw_i(raw),
    .state_i(state_q),
    .commit_o(commit),
    .pending_o(pending_o)
  );
  always_comb begin
    state_d = clr ? LVL_LOW : commit ? raw : state_q;
    chg_d = clr | commit;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= LVL_LOW;
      chg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chg_q <= chg_d;
    end
  assign state_o = state_q;
  assign state_chg_o = chg_q;
endmodule

// File: tb/tb_sum_level_tracker.sv
// tb_sum_level_tracker: directed self-checking bench for sum_level_tracker at default parameters
module tb_sum_level_tracker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] sum_i = '0;
  logic sum_valid_i = 1'b0;
  logic clr_over_i = 1'b0;
  logic [1:0] state_o;
  logic state_chg_o, pending_o;
  int checks = 0;
  int errors = 0;
  sum_level_tracker dut (
    .clk(clk),
    .rst_n(rst_n),
    .sum_i(sum_i),
    .sum_valid_i(sum_valid_i),
    .clr_over_i(clr_over_i),
    .state_o(state_o),
    .state_chg_o(state_chg_o),
    .pending_o(pending_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int s, input logic v);
    sum_i = 4'(s);
    sum_valid_i = v;
    @(posedge clk);
    #1;
  endtask
  task automatic outs(input string tag, input int st, input int chg, input int pend);
    chk({tag, "_state"}, int'(state_o), st);
    chk({tag, "_chg"}, int'(state_chg_o), chg);
    chk({tag, "_pend"}, int'(pending_o), pend);
  endtask
  initial begin
    #3;
    outs("reset", 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2, 1); outs("low_a", 0, 0, 0);
    step(2, 1); outs("low_b", 0, 0, 0);
    step(5, 1); outs("mid_1", 0, 0, 1);
    step(5, 1); outs("mid_2", 1, 1, 0);
    step(5, 1); outs("mid_3", 1, 0, 0);
    step(3, 1); outs("hyst_mid_1", 1, 0, 0);
    step(3, 1); outs("hyst_mid_2", 1, 0, 0);
    step(2, 1); outs("down_1", 1, 0, 1);
    step(2, 1); outs("down_2", 0, 1, 0);
    step(5, 1); outs("blip_1", 0, 0, 1);
    step(2, 1); outs("blip_2", 0, 0, 0);
    step(12, 1); outs("over_1", 0, 0, 1);
    step(12, 1); outs("over_2", 3, 1, 0);
    step(12, 1); outs("over_3", 3, 0, 0);
`ifdef SUM_LVL_STICKY_OVER_EN
    for (int i = 0; i < 5; i++) begin
      step(0, 1); outs("sticky", 3, 0, 0);
    end
    clr_over_i = 1'b1;
    step(0, 1); outs("clr", 0, 1, 0);
    clr_over_i = 1'b0;
    step(0, 1); outs("clr_after", 0, 0, 0);
`else
    step(0, 1); outs("exit_1", 3, 0, 1);
    step(0, 1); outs("exit_2", 0, 1, 0);
`endif
    step(9, 1); outs("gap_0", 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0); outs("gap", 0, 0, 1);
    end
    step(9, 1); outs("gap_commit", 2, 1, 0);
    step(7, 1); outs("hyst_high_1", 2, 0, 0);
    step(7, 1); outs("hyst_high_2", 2, 0, 0);
    step(12, 1); outs("pre_rst", 2, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    outs("async_rst", 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(12, 1); outs("post_rst", 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
